// File: rtl/conv_result_writer_pkg.sv
// Shared constants and FSM encoding for the binary conv result writer.
// Imported by the popcount sub-module and the writer top.
package conv_result_writer_pkg;

    localparam int TAPS   = 9;
    localparam int WORD_W = 16;
    localparam int THRESH = 4;
    localparam int ADDR_W = 12;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_result_writer_neg_count9.sv
// Combinational count of set negative_flags lanes for one output pixel.
// Produces a 4-bit count; 0..TAPS with the default 3x3 kernel.
module neg_count9 #(
    parameter int TAPS = conv_result_writer_pkg::TAPS
) (
    input  logic [TAPS-1:0] flags,
    output logic [3:0]      count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < TAPS; i++) begin
            count = count + {3'b000, flags[i]};
        end
    end

endmodule

// File: rtl/conv_result_writer.sv
// Packs thresholded pixel results into SRAM words and writes each word
// one cycle after its completing beat; FSM frames one image per go.
module conv_result_writer #(
    parameter int TAPS   = conv_result_writer_pkg::TAPS,
    parameter int WORD_W = conv_result_writer_pkg::WORD_W,
    parameter int THRESH = conv_result_writer_pkg::THRESH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic              flag_valid,
    input  logic [TAPS-1:0]   negative_flags,
    input  logic [11:0]       write_addr_in,
    input  logic [3:0]        idx_in,
    input  logic              last_in,
    output logic              sram_write_enable,
    output logic [11:0]       sram_write_address,
    output logic [WORD_W-1:0] sram_write_data,
    output logic              busy,
    output logic              done,
    output logic [11:0]       words_written
);

    import conv_result_writer_pkg::*;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        neg_n;
    logic              accept;
    logic              result_bit;
    logic              complete;
    logic [WORD_W-1:0] buffer;
    logic [WORD_W-1:0] merged;

    neg_count9 #(
        .TAPS (TAPS)
    ) u_neg_count (
        .flags (negative_flags),
        .count (neg_n)
    );

    always_comb begin
        accept     = (state == RUN) && flag_valid;
        result_bit = (neg_n <= 4'(THRESH));
        complete   = accept && ((idx_in == IDX_W'(WORD_W - 1)) || last_in);
        merged     = buffer;
        merged[idx_in] = result_bit;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = RUN;
            RUN:     if (flag_valid && last_in) state_nx = FLUSH;
            FLUSH:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The completing beat clears the buffer in the same edge it loads the
    // output word, so a beat during the strobe cycle lands in a clean buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer             <= '0;
            sram_write_enable  <= 1'b0;
            sram_write_address <= '0;
            sram_write_data    <= '0;
            words_written      <= '0;
        end else begin
            sram_write_enable <= complete;
            if (accept) begin
                buffer <= complete ? '0 : merged;
            end
            if (complete) begin
                sram_write_address <= write_addr_in;
                sram_write_data    <= merged;
            end
            if (state == IDLE && go) begin
                words_written <= '0;
            end else if (sram_write_enable) begin
                words_written <= words_written + 12'd1;
            end
        end
    end

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);

endmodule

// File: doc/conv_result_writer.md
CONV_RESULT_WRITER -- requirements
Module: conv_result_writer

Interface
REQ-001 Parameter TAPS, default 9: number of conv_module negative_flag lanes per output pixel (3x3 kernel).
REQ-002 Parameter WORD_W, default 16: output SRAM word width, equal to the pixels per word.
REQ-003 Parameter THRESH, default 4: maximum negative count that still yields a result bit of 1.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 go  input  1  start-of-image strobe, sampled in IDLE only.
REQ-007 flag_valid  input  1  negative_flags, write_addr_in, idx_in and last_in valid this cycle.
REQ-008 negative_flags  input  TAPS  per-tap weight XOR data (1 = product -1).
REQ-009 write_addr_in  input  12  destination SRAM word address for this pixel.
REQ-010 idx_in  input  4  bit position of this pixel within the word.
REQ-011 last_in  input  1  final pixel of the image.
REQ-012 sram_write_enable  output  1  one-cycle write strobe.
REQ-013 sram_write_address  output  12  address for the write.
REQ-014 sram_write_data  output  WORD_W  packed result word.
REQ-015 busy  output  1  high in RUN and FLUSH.
REQ-016 done  output  1  one-cycle pulse after the final write.
REQ-017 words_written  output  12  count of words written since the last accepted go.

Function
REQ-018 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on go; RUN->FLUSH on flag_valid&&last_in; FLUSH->DONE unconditionally; DONE->IDLE unconditionally.
REQ-019 go outside IDLE shall be ignored; flag_valid outside RUN shall be ignored, with no buffer change and no write.
REQ-020 Per valid beat: n = popcount(negative_flags) (0..TAPS); result bit = 1 if n <= THRESH, else 0 (sign of the ±1 sum, with positive sum -> 1).
REQ-021 Result bit shall be written into the accumulation buffer at position idx_in; unwritten positions shall remain 0.
REQ-022 A beat with idx_in==WORD_W-1 or last_in shall load {buffer with the current bit} into the output registers, drive sram_write_address = write_addr_in, and clear the buffer in the same edge.
REQ-023 sram_write_enable shall be high exactly the one cycle after the completing beat (latency 1); data and address shall be stable throughout that cycle.
REQ-024 A valid beat in the cycle that sram_write_enable is high shall be accepted into the cleared buffer without loss; back-to-back completing beats shall produce back-to-back writes.
REQ-025 idx_in==WORD_W-1 with last_in shall produce exactly one write.
REQ-026 words_written shall clear on an accepted go, increment by 1 per write, and wrap from 4095 to 0.
REQ-027 done shall pulse in state DONE only, the cycle after the last write's strobe.

Reset
REQ-028 Reset asserted shall immediately force state IDLE and set sram_write_enable, sram_write_address, sram_write_data, busy, done, words_written, and the buffer to 0.
REQ-029 Reset mid-image shall discard the partial word with no write, and after release shall wait for a new go.

Structure
REQ-030 Shared package shall hold TAPS, WORD_W, THRESH, ADDR_W=12, IDX_W=4, and the FSM state encoding.
REQ-031 Popcount shall be a separate combinational sub-module, neg_count9 (TAPS inputs, 4-bit count).

Verification
REQ-032 go, 16 beats with flags=0, idx 0..15, addr=0x010 -> one write: addr 0x010, data 0xFFFF; words_written=1.
REQ-033 go, beat idx=3 flags=9'h01F (n=5), beat idx=4 flags=9'h00F (n=4) with last_in -> write data 0x0010; done pulses 1 cycle after the strobe; busy falls.
REQ-034 Word completing at idx 15 (addr 0x020), next cycle idx 0 flags=0 (addr 0x021) -> write 0x020 strobed while the new bit is captured; later write to 0x021 has bit0=1.
REQ-035 Reset asserted after 7 beats -> outputs 0 asynchronously, no write; go then 1 beat with last_in -> single write, words_written=1.
REQ-036 flag_valid in IDLE and go during RUN -> no buffer change, no write, words_written unchanged.
